collision_scanner: RTL and testbench

Sequential, parametrised successor to the combinational ship/meteor collision detector. On each `start` pulse (typically the frame tick), it snapshots the ship position and all meteor positions. It then tests one meteor per clock against the ship with an axis-aligned bounding-box overlap check, and publishes double-buffered results with a one-cycle `done` pulse. The game FSM consumes these results, and the sticky mode lets it accumulate hits across frames until it explicitly clears them.

---
 rtl/collision_scanner.sv | 188 ++++++++++++++++++
 tb/tb_collision_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scanner.sv
// Sequential ship/meteor collision scanner: snapshots all positions on start,
// tests one meteor per clock, then publishes double-buffered results with a done pulse.

module collision_box_hit #(
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int SHIP_WIDTH  = 40,
  parameter int SHIP_HEIGHT = 15,
  parameter int METEOR_SIZE = 30
) (
  input  logic           active_i,
  input  logic [X_W-1:0] sx_i,
  input  logic [Y_W-1:0] sy_i,
  input  logic [X_W-1:0] mx_i,
  input  logic [Y_W-1:0] my_i,
  output logic           hit_o
);
  // Two guard bits so coordinate + box size can never wrap.
  localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 2;

  logic [CW-1:0] sx, sy, mx, my;

  assign sx = CW'(sx_i);
  assign sy = CW'(sy_i);
  assign mx = CW'(mx_i);
  assign my = CW'(my_i);

  // Strict compares: edge-adjacent boxes do not collide.
  assign hit_o = active_i
              && (mx < sx + CW'(SHIP_WIDTH))
              && (mx + CW'(METEOR_SIZE) > sx)
              && (my < sy + CW'(SHIP_HEIGHT))
              && (my + CW'(METEOR_SIZE) > sy);
endmodule

module collision_scanner #(
  parameter int N_METEORS   = 6,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int SHIP_WIDTH  = 40,
  parameter int SHIP_HEIGHT = 15,
  parameter int METEOR_SIZE = 30,
  parameter bit STICKY      = 1'b0,
  localparam int IDX_W      = (N_METEORS > 1) ? $clog2(N_METEORS) : 1,
  localparam int CNT_W      = $clog2(N_METEORS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear,
  input  logic [X_W-1:0]       ship_x,
  input  logic [Y_W-1:0]       ship_y,
  input  logic [X_W-1:0]       meteor_x [N_METEORS],
  input  logic [Y_W-1:0]       meteor_y [N_METEORS],
  input  logic [N_METEORS-1:0] meteor_active,
  output logic                 busy,
  output logic                 done,
  output logic                 collision,
  output logic [N_METEORS-1:0] meteor_collisions,
  output logic [IDX_W-1:0]     first_hit_idx,
  output logic [CNT_W-1:0]     hit_count
);
  typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_METEORS-1:0] scr_q, scr_d;
  logic [N_METEORS-1:0] pub_q, pub_d;
  logic [IDX_W-1:0]     fh_q, fh_d;
  logic [CNT_W-1:0]     hc_q, hc_d;

  logic [X_W-1:0]       sx_q;
  logic [Y_W-1:0]       sy_q;
  logic [X_W-1:0]       mx_q [N_METEORS];
  logic [Y_W-1:0]       my_q [N_METEORS];
  logic [N_METEORS-1:0] act_q;

  logic                 accept;
  logic                 cur_hit;
  logic [IDX_W-1:0]     first_c;
  logic [CNT_W-1:0]     cnt_c;

  collision_box_hit #(
    .X_W(X_W), .Y_W(Y_W), .SHIP_WIDTH(SHIP_WIDTH),
    .SHIP_HEIGHT(SHIP_HEIGHT), .METEOR_SIZE(METEOR_SIZE)
  ) u_hit (
    .active_i (act_q[idx_q]),
    .sx_i     (sx_q),
    .sy_i     (sy_q),
    .mx_i     (mx_q[idx_q]),
    .my_i     (my_q[idx_q]),
    .hit_o    (cur_hit)
  );

  // Summary of the scratch flags, consumed only in PUBLISH when scratch is complete.
  always_comb begin
    first_c = '0;
    cnt_c   = '0;
    for (int i = N_METEORS - 1; i >= 0; i--)
      if (scr_q[i]) first_c = IDX_W'(i);
    for (int i = 0; i < N_METEORS; i++)
      cnt_c = cnt_c + CNT_W'(scr_q[i]);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    scr_d   = scr_q;
    pub_d   = pub_q;
    fh_d    = fh_q;
    hc_d    = hc_q;
    accept  = 1'b0;
    if (clear) begin
      pub_d = '0;
      fh_d  = '0;
      hc_d  = '0;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          scr_d   = '0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        scr_d[idx_q] = cur_hit;
        if (idx_q == IDX_W'(N_METEORS - 1)) state_d = PUBLISH;
        else                                idx_d   = idx_q + IDX_W'(1);
      end
      PUBLISH: begin
        // A coincident clear drops the old flags but keeps this scan's hits.
        pub_d   = (STICKY && !clear) ? (pub_q | scr_q) : scr_q;
        fh_d    = first_c;
        hc_d    = cnt_c;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      scr_q   <= '0;
      pub_q   <= '0;
      fh_q    <= '0;
      hc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      scr_q   <= scr_d;
      pub_q   <= pub_d;
      fh_q    <= fh_d;
      hc_q    <= hc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sx_q  <= '0;
      sy_q  <= '0;
      act_q <= '0;
      for (int i = 0; i < N_METEORS; i++) begin
        mx_q[i] <= '0;
        my_q[i] <= '0;
      end
    end else if (accept) begin
      sx_q  <= ship_x;
      sy_q  <= ship_y;
      act_q <= meteor_active;
      for (int i = 0; i < N_METEORS; i++) begin
        mx_q[i] <= meteor_x[i];
        my_q[i] <= meteor_y[i];
      end
    end
  end

  // In the done cycle the fresh results are already visible alongside the pulse.
  assign busy              = (state_q != IDLE);
  assign done              = (state_q == PUBLISH);
  assign meteor_collisions = done ? pub_d : pub_q;
  assign first_hit_idx     = done ? fh_d  : fh_q;
  assign hit_count         = done ? hc_d  : hc_q;
  assign collision         = |meteor_collisions;
endmodule

// File: tb/tb_collision_scanner.sv
// Scoreboard bench: a non-sticky and a sticky scanner share stimulus and are
// compared each cycle and at every done against a box-overlap reference model.

module tb_collision_scanner;
  localparam int N  = 6;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int IW = 3;
  localparam int CW = 3;

  typedef struct {
    int         k;
    bit [N-1:0] mc;
    int         fh;
    int         hc;
    int         start_cyc;
  } exp_t;

  exp_t q[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, clear;
  logic [XW-1:0] ship_x;
  logic [YW-1:0] ship_y;
  logic [XW-1:0] meteor_x [N];
  logic [YW-1:0] meteor_y [N];
  logic [N-1:0]  meteor_active;

  logic          busy_o [2];
  logic          done_o [2];
  logic          coll_o [2];
  logic [N-1:0]  mc_o   [2];
  logic [IW-1:0] fh_o   [2];
  logic [CW-1:0] hc_o   [2];

  collision_scanner #(.N_METEORS(N), .X_W(XW), .Y_W(YW), .SHIP_WIDTH(40),
    .SHIP_HEIGHT(15), .METEOR_SIZE(30), .STICKY(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .ship_x(ship_x), .ship_y(ship_y), .meteor_x(meteor_x), .meteor_y(meteor_y),
    .meteor_active(meteor_active), .busy(busy_o[0]), .done(done_o[0]),
    .collision(coll_o[0]), .meteor_collisions(mc_o[0]),
    .first_hit_idx(fh_o[0]), .hit_count(hc_o[0]));

  collision_scanner #(.N_METEORS(N), .X_W(XW), .Y_W(YW), .SHIP_WIDTH(40),
    .SHIP_HEIGHT(15), .METEOR_SIZE(30), .STICKY(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .ship_x(ship_x), .ship_y(ship_y), .meteor_x(meteor_x), .meteor_y(meteor_y),
    .meteor_active(meteor_active), .busy(busy_o[1]), .done(done_o[1]),
    .collision(coll_o[1]), .meteor_collisions(mc_o[1]),
    .first_hit_idx(fh_o[1]), .hit_count(hc_o[1]));

  // Reference model state
  int         cyc = 0;
  bit         m_busy = 0;
  int         m_start = 0, m_due = 0;
  bit [N-1:0] m_scr = '0;
  bit [N-1:0] m_pub [2];
  int         m_fh [2];
  int         m_hc [2];
  // What the DUTs should present during the current cycle
  bit         v_busy = 0, v_done = 0;
  bit [N-1:0] v_mc [2];
  int         v_fh [2];
  int         v_hc [2];
  bit         mon_en = 0;
  int         n_chk = 0, n_pass = 0;

  function automatic bit box_hit(int sx, int sy, int mx, int my, bit a);
    return a && (mx < sx + 40) && (mx + 30 > sx) && (my < sy + 15) && (my + 30 > sy);
  endfunction

  function automatic int first_of(bit [N-1:0] f);
    for (int i = 0; i < N; i++) if (f[i]) return i;
    return 0;
  endfunction

  function automatic int popc(bit [N-1:0] f);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(f[i]);
    return c;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Advance the model by one cycle using the inputs currently driven, then clock.
  task automatic tick();
    bit [N-1:0] nf;
    int fh, hc;
    exp_t e;
    fh = first_of(m_scr);
    hc = popc(m_scr);
    if (m_busy && cyc == m_due) begin
      v_done = 1; v_busy = 1;
      for (int k = 0; k < 2; k++) begin
        nf = (k == 1 && !clear) ? (m_pub[k] | m_scr) : m_scr;
        v_mc[k] = nf; v_fh[k] = fh; v_hc[k] = hc;
        e.k = k; e.mc = nf; e.fh = fh; e.hc = hc; e.start_cyc = m_start;
        q.push_back(e);
        m_pub[k] = nf; m_fh[k] = fh; m_hc[k] = hc;
      end
      m_busy = 0;
    end else begin
      v_done = 0; v_busy = m_busy;
      for (int k = 0; k < 2; k++) begin
        v_mc[k] = m_pub[k]; v_fh[k] = m_fh[k]; v_hc[k] = m_hc[k];
        if (clear) begin m_pub[k] = '0; m_fh[k] = 0; m_hc[k] = 0; end
      end
      if (!m_busy && start) begin
        m_busy = 1; m_start = cyc; m_due = cyc + N + 1;
        for (int i = 0; i < N; i++)
          m_scr[i] = box_hit(int'(ship_x), int'(ship_y), int'(meteor_x[i]),
                             int'(meteor_y[i]), meteor_active[i]);
      end
    end
    if (reset) begin
      m_busy = 0; m_scr = '0;
      for (int k = 0; k < 2; k++) begin m_pub[k] = '0; m_fh[k] = 0; m_hc[k] = 0; end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy[%0d]", k), int'(busy_o[k]), int'(v_busy));
        chk($sformatf("done[%0d]", k), int'(done_o[k]), int'(v_done));
        chk($sformatf("flags[%0d]", k), int'(mc_o[k]), int'(v_mc[k]));
        chk($sformatf("collision[%0d]", k), int'(coll_o[k]), int'(|v_mc[k]));
        chk($sformatf("first_hit[%0d]", k), int'(fh_o[k]), v_fh[k]);
        chk($sformatf("hit_count[%0d]", k), int'(hc_o[k]), v_hc[k]);
        if (done_o[k]) begin
          if (q.size() == 0) chk($sformatf("sb_entry[%0d]", k), 0, 1);
          else begin
            e = q.pop_front();
            chk($sformatf("sb_dut[%0d]", k), k, e.k);
            chk($sformatf("sb_latency[%0d]", k), cyc - e.start_cyc, N + 1);
            chk($sformatf("sb_flags[%0d]", k), int'(mc_o[k]), int'(e.mc));
            chk($sformatf("sb_first[%0d]", k), int'(fh_o[k]), e.fh);
            chk($sformatf("sb_count[%0d]", k), int'(hc_o[k]), e.hc);
          end
        end
      end
    end
  end

  task automatic set_all(int x, int y, bit a);
    for (int i = 0; i < N; i++) begin
      meteor_x[i] = XW'(x); meteor_y[i] = YW'(y); meteor_active[i] = a;
    end
  endtask

  task automatic set_m(int i, int x, int y, bit a);
    meteor_x[i] = XW'(x); meteor_y[i] = YW'(y); meteor_active[i] = a;
  endtask

  task automatic set_ship(int x, int y);
    ship_x = XW'(x); ship_y = YW'(y);
  endtask

  // start, N scan cycles (start optionally re-pulsed), then the publish cycle
  task automatic run_scan(bit clr_pub, bit repulse);
    start = 1; tick(); start = 0;
    for (int i = 0; i < N; i++) begin
      start = repulse && (i == 2);
      tick();
    end
    start = 0;
    clear = clr_pub; tick(); clear = 0;
    tick();
  endtask

  initial begin
    int bx [5];
    int by [5];
    int sx, sy, t;
    bx = '{339, 340, 270, 271, 300};
    by = '{254, 254, 240, 240, 210};
    for (int k = 0; k < 2; k++) begin m_pub[k] = '0; m_fh[k] = 0; m_hc[k] = 0; end
    reset = 1; start = 0; clear = 0;
    set_ship(0, 0); set_all(0, 0, 0);
    tick();
    mon_en = 1;
    tick();
    reset = 0;
    tick();

    // all inactive
    set_ship(300, 240); set_all(700, 500, 0);
    run_scan(0, 0);

    // two overlapping meteors among four misses
    set_m(0, 100, 100, 1); set_m(1, 305, 245, 1); set_m(2, 500, 100, 1);
    set_m(3, 300, 50, 1);  set_m(4, 310, 248, 1); set_m(5, 300, 400, 1);
    run_scan(0, 0);

    // edge adjacency versus one-pixel overlap
    set_all(700, 500, 0);
    for (int j = 0; j < 5; j++) begin
      set_m(2, bx[j], by[j], 1);
      run_scan(0, 0);
    end

    // far-edge coordinates must not wrap
    set_all(700, 500, 0);
    set_ship(1000, 500); set_m(0, 1020, 505, 1); run_scan(0, 0);
    set_ship(0, 0);      set_m(0, 1010, 0, 1);   run_scan(0, 0);

    // accumulation, clear pulse, clear coincident with publish
    clear = 1; tick(); clear = 0;
    set_ship(300, 240); set_all(700, 500, 1);
    set_m(0, 305, 245, 1); run_scan(0, 0);
    set_m(0, 700, 500, 1); set_m(3, 305, 245, 1); run_scan(0, 0);
    clear = 1; tick(); clear = 0; tick();
    set_m(3, 700, 500, 1); set_m(5, 305, 245, 1); run_scan(1, 0);

    // start re-pulsed mid-scan, then reset in the third scan cycle
    set_m(2, 310, 250, 1);
    run_scan(0, 1);
    start = 1; tick(); start = 0;
    tick(); tick();
    reset = 1; tick(); reset = 0;
    tick(); tick();
    run_scan(0, 0);

    // random traffic, inputs changing every cycle
    for (int c = 0; c < 900; c++) begin
      sx = int'($urandom_range(0, 1023)); sy = int'($urandom_range(0, 511));
      set_ship(sx, sy);
      for (int i = 0; i < N; i++) begin
        t = sx - 45 + int'($urandom_range(0, 90));
        meteor_x[i] = XW'((t < 0) ? 0 : (t > 1023) ? 1023 : t);
        t = sy - 35 + int'($urandom_range(0, 60));
        meteor_y[i] = YW'((t < 0) ? 0 : (t > 511) ? 511 : t);
        meteor_active[i] = ($urandom_range(0, 3) != 0);
      end
      start = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 99) == 0) && !(m_busy && cyc == m_due);
      tick();
    end
    reset = 0; start = 0; clear = 0;
    for (int i = 0; i < N + 4; i++) tick();
    mon_en = 0;
    chk("sb_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
